// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential multiplier.
// Holds FSM state encodings and ALU control codes.
package mul_seq_pkg;

  localparam int W  = 64;
  localparam int CW = 6;

  typedef enum logic [1:0] {
    MST_IDLE = 2'd0,
    MST_RUN  = 2'd1,
    MST_DONE = 2'd2
  } mst_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

endpackage

// File: rtl/mul_seq_alu.sv
// LEGv8-style 64-bit ALU.
// The multiplier uses it only for wrapping addition.
module mul_seq_alu
  import mul_seq_pkg::*;
(
  input  logic [3:0]   alu_ctrl_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         zero_o
);

  // Operation select
  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_AND:   result_o = a_i & b_i;
      ALU_ORR:   result_o = a_i | b_i;
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_PASSB: result_o = b_i;
      ALU_NOR:   result_o = ~(a_i | b_i);
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add 64-bit multiplier, low half of product.
// Terminates early once the remaining multiplier bits are zero.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         flush,
  output logic         busy,
  output logic         stall,
  output logic         done,
  output logic [W-1:0] product
);

  mst_e          state_q, state_d;
  logic [W-1:0]  acc_q, mcand_q, mplier_q, product_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  alu_sum, acc_d, mplier_nxt;
  logic          accept, run_end;
  logic          alu_zero_unused;

  mul_seq_alu u_alu (
    .alu_ctrl_i (ALU_ADD),
    .a_i        (acc_q),
    .b_i        (mcand_q),
    .result_o   (alu_sum),
    .zero_o     (alu_zero_unused)
  );

  assign accept     = (state_q == MST_IDLE) & start & ~flush;
  assign mplier_nxt = mplier_q >> 1;
  assign run_end    = (cnt_q == 6'd63) | (mplier_nxt == '0);
  assign acc_d      = mplier_q[0] ? alu_sum : acc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush aborts RUN without a done pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      MST_IDLE: if (accept) state_d = MST_RUN;
      MST_RUN: begin
        if (flush)        state_d = MST_IDLE;
        else if (run_end) state_d = MST_DONE;
      end
      MST_DONE: state_d = MST_IDLE;
      default:  state_d = MST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy  = (state_q == MST_RUN);
    done  = (state_q == MST_DONE);
    stall = (state_q == MST_RUN) | accept;
  end

  // Datapath: capture on accept, one shift-add step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= op_a;
      mplier_q <= op_b;
      cnt_q    <= '0;
    end else if (state_q == MST_RUN && !flush) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_nxt;
      cnt_q    <= cnt_q + 6'd1;
      if (run_end) product_q <= acc_d;
    end
  end

  assign product = product_q;

endmodule
